// File: rtl/m72_irq_ctrl.sv
// m72_irq_ctrl: latches VBLK-rise and HINT raster-match events as CPU interrupt
// requests, runs the V30 two-INTA acknowledge handshake and returns the vector
// of the serviced source on the second acknowledge. Also hosts the CPU-writable
// enable / pending-clear register.
module m72_irq_ctrl #(
  parameter logic [7:0] VBL_VECTOR   = 8'h20,
  parameter logic [7:0] HINT_VECTOR  = 8'h22,
  parameter int         VBL_PRIORITY = 1
) (
  input  logic       CLK_32M,
  input  logic       RESET,
  input  logic       VBLK,
  input  logic       HINT,
  input  logic       WR,
  input  logic [7:0] D,
  input  logic       INTA,
  output logic       INT_REQ,
  output logic [7:0] INT_VECTOR,
  output logic       VECTOR_VALID,
  output logic [1:0] PENDING,
  output logic [1:0] ENABLE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK1 = 2'd2
  } state_t;

  state_t     state;
  logic       vblk_d;
  logic       hint_d;
  logic       src_hint;   // source chosen for the handshake: 1 = HINT, 0 = VBL
  logic [7:0] vec_lat;    // vector of the chosen source

  logic [1:0] rise;
  logic [1:0] active;
  logic       sel_hint;
  logic [1:0] wr_clr;
  logic [1:0] ack_clr;
  logic [1:0] pend_nxt;

  // D[5:2] carry no register bits
  logic       unused_d;
  assign unused_d = ^D[5:2];

  // Returns 1 when HINT should be serviced among the active sources.
  function automatic logic pick_hint(input logic [1:0] act);
    logic win;
    if (act == 2'b11)
      win = (VBL_PRIORITY == 0);
    else
      win = act[1];
    return win;
  endfunction

  // Vector belonging to a source.
  function automatic logic [7:0] vector_of(input logic is_hint);
    return is_hint ? HINT_VECTOR : VBL_VECTOR;
  endfunction

  // Edge detection, pending set/clear resolution (set always beats clear)
  always_comb begin
    rise     = {HINT & ~hint_d, VBLK & ~vblk_d} & ENABLE;
    active   = PENDING & ENABLE;
    sel_hint = pick_hint(active);
    wr_clr   = WR ? {D[7], D[6]} : 2'b00;
    ack_clr  = 2'b00;
    if (state == ACK1 && INTA)
      ack_clr = src_hint ? 2'b10 : 2'b01;
    pend_nxt = (PENDING & ~(wr_clr | ack_clr)) | rise;
  end

  // Input history, pending bits and the enable register
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      vblk_d  <= 1'b0;
      hint_d  <= 1'b0;
      PENDING <= 2'b00;
      ENABLE  <= 2'b00;
    end else begin
      vblk_d  <= VBLK;
      hint_d  <= HINT;
      PENDING <= pend_nxt;
      if (WR)
        ENABLE <= D[1:0];
    end
  end

  // Request / two-cycle acknowledge handshake with registered outputs
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      INT_REQ      <= 1'b0;
      INT_VECTOR   <= 8'h00;
      VECTOR_VALID <= 1'b0;
      src_hint     <= 1'b0;
      vec_lat      <= 8'h00;
    end else begin
      VECTOR_VALID <= 1'b0;
      case (state)
        IDLE: begin
          // INTA here belongs to nobody and is ignored
          if (active != 2'b00) begin
            state    <= REQ;
            INT_REQ  <= 1'b1;
            src_hint <= sel_hint;
            vec_lat  <= vector_of(sel_hint);
          end
        end
        REQ: begin
          if (INTA) begin
            // Re-resolve at acknowledge time; if the request was just
            // withdrawn, keep the source captured on entry.
            if (active != 2'b00) begin
              src_hint <= sel_hint;
              vec_lat  <= vector_of(sel_hint);
            end
            INT_REQ <= 1'b0;
            state   <= ACK1;
          end else if (active == 2'b00) begin
            INT_REQ <= 1'b0;
            state   <= IDLE;
          end
        end
        ACK1: begin
          if (INTA) begin
            INT_VECTOR   <= vec_lat;
            VECTOR_VALID <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          INT_REQ <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
